// File: rtl/ram_cmd_pkg.sv
// Shared types for the command-driven burst RAM: command opcodes and controller states.
package ram_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int OP_W = 2;

endpackage

// File: rtl/ram_cmd_burst_if.sv
// Command (rx) and read-data (tx) valid/ready channels of the burst RAM.
interface ram_cmd_burst_if
  import ram_cmd_pkg::*;
#(
  parameter int DATA_W = 8
);

  logic [DATA_W+OP_W-1:0] din;
  logic                   rx_valid;
  logic                   rx_ready;
  logic [DATA_W-1:0]      dout;
  logic                   tx_valid;
  logic                   tx_ready;

  modport master (
    output din, rx_valid, tx_ready,
    input  rx_ready, dout, tx_valid
  );

  modport slave (
    input  din, rx_valid, tx_ready,
    output rx_ready, dout, tx_valid
  );

endinterface

// File: rtl/ram_sp_array.sv
// Single-port storage: synchronous write, registered read that holds until the next read enable.
// Read register clears on reset so an idle output is defined; the array itself is never cleared.
module ram_sp_array
  import ram_cmd_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdat,
  output logic [DATA_W-1:0] o_rdat
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdat;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdat;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdat <= '0;
    end else if (i_re) begin
      r_rdat <= r_mem[i_addr];
    end
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/ram_cmd_burst.sv
// Command-driven RAM: opcode words set addresses/write data or launch 1..2**LEN_W word read bursts.
// Read word appears one cycle after accept; commands are refused while any read word is pending.
module ram_cmd_burst
  import ram_cmd_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int AUTO_INC = 1,
  parameter int LEN_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_cmd_burst_if.slave   cmd_if
);

  localparam logic [ADDR_W-1:0] ADDR_INC = (AUTO_INC != 0) ? ADDR_W'(1) : '0;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] w_wr_addr_nxt;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] w_rd_addr_nxt;
  logic [LEN_W-1:0]  r_remaining;
  logic [LEN_W-1:0]  w_remaining_nxt;
  logic              r_tx_valid;
  logic              w_tx_valid_nxt;
  logic              r_out_en;

  cmd_op_t           w_op;
  logic [ADDR_W-1:0] w_pl_addr;
  logic [LEN_W-1:0]  w_pl_len;
  logic              w_rx_ready;
  logic              w_accept;
  logic              w_tx_hs;
  logic              w_launch;
  logic              w_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_rdat;

  assign w_op      = cmd_op_t'(cmd_if.din[DATA_W+OP_W-1:DATA_W]);
  assign w_pl_addr = cmd_if.din[ADDR_W-1:0];
  assign w_pl_len  = cmd_if.din[LEN_W-1:0];

  // r_out_en keeps rx_ready low for the first cycle after reset release
  assign w_rx_ready = r_out_en && (r_state == IDLE) && !r_tx_valid;
  assign w_accept   = cmd_if.rx_valid && w_rx_ready;
  assign w_tx_hs    = r_tx_valid && cmd_if.tx_ready;
  assign w_we       = w_accept && (w_op == CMD_WR_DATA);

  always_comb begin
    w_state_nxt     = r_state;
    w_wr_addr_nxt   = r_wr_addr;
    w_rd_addr_nxt   = r_rd_addr;
    w_remaining_nxt = r_remaining;
    w_tx_valid_nxt  = r_tx_valid;
    w_launch        = 1'b0;

    if (w_tx_hs) begin
      w_tx_valid_nxt = 1'b0;
    end

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (w_op)
            CMD_WR_ADDR: w_wr_addr_nxt = w_pl_addr;
            CMD_WR_DATA: w_wr_addr_nxt = r_wr_addr + ADDR_INC;
            CMD_RD_ADDR: w_rd_addr_nxt = w_pl_addr;
            CMD_RD_DATA: begin
              w_launch        = 1'b1;
              w_tx_valid_nxt  = 1'b1;
              w_remaining_nxt = w_pl_len;
              if (w_pl_len != '0) begin
                w_state_nxt = BURST;
              end
            end
          endcase
        end
      end
      BURST: begin
        // BURST always holds at least one more word; the last launch hands back to IDLE
        if (w_tx_hs && (r_remaining != '0)) begin
          w_launch        = 1'b1;
          w_tx_valid_nxt  = 1'b1;
          w_remaining_nxt = r_remaining - LEN_W'(1);
          if (r_remaining == LEN_W'(1)) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_launch) begin
      w_rd_addr_nxt = r_rd_addr + ADDR_INC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_remaining <= '0;
      r_tx_valid  <= 1'b0;
      r_out_en    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_remaining <= w_remaining_nxt;
      r_tx_valid  <= w_tx_valid_nxt;
      r_out_en    <= 1'b1;
    end
  end

  // Writes and launches never coincide, so one shared address port suffices
  assign w_ram_addr = w_we ? r_wr_addr : r_rd_addr;

  ram_sp_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_we    (w_we),
    .i_re    (w_launch),
    .i_addr  (w_ram_addr),
    .i_wdat  (cmd_if.din[DATA_W-1:0]),
    .o_rdat  (w_rdat)
  );

  assign cmd_if.rx_ready = w_rx_ready;
  assign cmd_if.tx_valid = r_tx_valid;
  assign cmd_if.dout     = w_rdat;

endmodule

// File: tb/tb_ram_cmd_burst.sv
// Bench for ram_cmd_burst: vector table on an AUTO_INC=0 instance, directed and random traffic
// on an AUTO_INC=1 instance checked against a command-level memory/queue model.
module tb_ram_cmd_burst;
  import ram_cmd_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ram_cmd_burst_if #(.DATA_W(8)) if1 ();
  ram_cmd_burst_if #(.DATA_W(8)) if0 ();

  ram_cmd_burst #(.ADDR_W(8), .DATA_W(8), .AUTO_INC(1), .LEN_W(4)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cmd_if (if1)
  );

  ram_cmd_burst #(.ADDR_W(8), .DATA_W(8), .AUTO_INC(0), .LEN_W(4)) u_dut0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .cmd_if (if0)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory image, address pointers and queue of words owed on tx
  logic [7:0] ref_mem [256];
  logic [7:0] ref_wr = 8'h00;
  logic [7:0] ref_rd = 8'h00;
  logic [7:0] exp_q [$];
  logic       hold = 1'b0;
  logic [7:0] hold_dat = 8'h00;
  logic [7:0] exp_word;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      ref_wr = 8'h00;
      ref_rd = 8'h00;
      hold   = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", {31'b0, if1.tx_valid}, 32'd1);
        check("hold_dout", {24'b0, if1.dout}, {24'b0, hold_dat});
      end
      if (if1.rx_valid && if1.rx_ready) begin
        case (if1.din[9:8])
          2'b00: ref_wr = if1.din[7:0];
          2'b01: begin
            ref_mem[ref_wr] = if1.din[7:0];
            ref_wr = ref_wr + 8'd1;
          end
          2'b10: ref_rd = if1.din[7:0];
          default: begin
            for (int i = 0; i <= int'(if1.din[3:0]); i++) begin
              exp_q.push_back(ref_mem[ref_rd]);
              ref_rd = ref_rd + 8'd1;
            end
          end
        endcase
      end
      if (if1.tx_valid && if1.tx_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tx_extra: unexpected word %0h with nothing owed at %0t", if1.dout, $time);
        end else begin
          exp_word = exp_q.pop_front();
          check("tx_word", {24'b0, if1.dout}, {24'b0, exp_word});
        end
      end
      hold     = if1.tx_valid && !if1.tx_ready;
      hold_dat = if1.dout;
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] pl, input bit rnd_tr);
    bit acc;
    int n;
    if1.din      = {op, pl};
    if1.rx_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = if1.rx_ready;
      @(posedge clk);
      #1;
      n++;
      if (rnd_tr && !acc) if1.tx_ready = ($urandom_range(0, 3) != 0);
    end
    if1.rx_valid = 1'b0;
    check("cmd_accepted", {31'b0, acc}, 32'd1);
  endtask

  task automatic wait_drain();
    int n;
    if1.tx_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || if1.tx_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue", exp_q.size(), 32'd0);
    check("drain_valid", {31'b0, if1.tx_valid}, 32'd0);
  endtask

  typedef struct {
    logic       rv;
    logic [9:0] din;
    logic       tr;
    logic       e_rr;
    logic       e_tv;
    logic [7:0] e_dout;
  } vec_t;

  vec_t vt [14];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b1, 10'h010, 1'b1, 1'b1, 1'b0, 8'h00};
    vt[1]  = '{1'b1, 10'h1A5, 1'b1, 1'b1, 1'b0, 8'h00};
    vt[2]  = '{1'b1, 10'h210, 1'b1, 1'b1, 1'b0, 8'h00};
    vt[3]  = '{1'b1, 10'h300, 1'b1, 1'b0, 1'b1, 8'hA5};
    vt[4]  = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 8'h00};
    vt[5]  = '{1'b1, 10'h301, 1'b1, 1'b0, 1'b1, 8'hA5};
    vt[6]  = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 8'hA5};
    vt[7]  = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 8'h00};
    vt[8]  = '{1'b1, 10'h177, 1'b1, 1'b1, 1'b0, 8'h00};
    vt[9]  = '{1'b1, 10'h3F0, 1'b1, 1'b0, 1'b1, 8'h77};
    vt[10] = '{1'b1, 10'h199, 1'b0, 1'b0, 1'b1, 8'h77};
    vt[11] = '{1'b1, 10'h199, 1'b1, 1'b1, 1'b0, 8'h00};
    vt[12] = '{1'b1, 10'h300, 1'b1, 1'b0, 1'b1, 8'h77};
    vt[13] = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 8'h00};

    if1.din = '0; if1.rx_valid = 1'b0; if1.tx_ready = 1'b1;
    if0.din = '0; if0.rx_valid = 1'b0; if0.tx_ready = 1'b1;

    // Reset values while rst_n is low, then rx_ready rises one cycle after release
    #2 rst_n = 1'b0;
    #1;
    check("rst_tv1", {31'b0, if1.tx_valid}, 32'd0);
    check("rst_dout1", {24'b0, if1.dout}, 32'd0);
    check("rst_rr1", {31'b0, if1.rx_ready}, 32'd0);
    check("rst_tv0", {31'b0, if0.tx_valid}, 32'd0);
    check("rst_rr0", {31'b0, if0.rx_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rel_rr_low", {31'b0, if1.rx_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("rel_rr_high1", {31'b0, if1.rx_ready}, 32'd1);
    check("rel_rr_high0", {31'b0, if0.rx_ready}, 32'd1);

    // AUTO_INC=0 vector table
    for (int i = 0; i < 14; i++) begin
      if0.rx_valid = vt[i].rv;
      if0.din      = vt[i].din;
      if0.tx_ready = vt[i].tr;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_rr", i), {31'b0, if0.rx_ready}, {31'b0, vt[i].e_rr});
      check($sformatf("vec%0d_tv", i), {31'b0, if0.tx_valid}, {31'b0, vt[i].e_tv});
      if (vt[i].e_tv) check($sformatf("vec%0d_dout", i), {24'b0, if0.dout}, {24'b0, vt[i].e_dout});
    end
    if0.rx_valid = 1'b0;

    // Streaming write then a 4-word burst at full rate
    send(2'b00, 8'h20, 1'b0);
    for (int v = 1; v <= 5; v++) send(2'b01, 8'(v), 1'b0);
    send(2'b10, 8'h20, 1'b0);
    send(2'b11, 8'h03, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("stream_tv", {31'b0, if1.tx_valid}, 32'd1);
      check("stream_dout", {24'b0, if1.dout}, 32'(k + 1));
      check("stream_rr", {31'b0, if1.rx_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    check("stream_end_tv", {31'b0, if1.tx_valid}, 32'd0);

    // Back-pressure mid-burst
    send(2'b10, 8'h20, 1'b0);
    send(2'b11, 8'h03, 1'b0);
    @(posedge clk);
    #1;
    if1.tx_ready = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_tv", {31'b0, if1.tx_valid}, 32'd1);
      check("bp_dout", {24'b0, if1.dout}, 32'h02);
    end
    wait_drain();
    send(2'b11, 8'h00, 1'b0);
    check("bp_next_addr", {24'b0, if1.dout}, 32'h05);
    wait_drain();

    // Address wrap-around
    send(2'b00, 8'hFF, 1'b0);
    send(2'b01, 8'hEE, 1'b0);
    send(2'b01, 8'h11, 1'b0);
    send(2'b10, 8'hFF, 1'b0);
    send(2'b11, 8'h01, 1'b0);
    check("wrap_first", {24'b0, if1.dout}, 32'hEE);
    @(posedge clk);
    #1;
    check("wrap_second", {24'b0, if1.dout}, 32'h11);
    wait_drain();

    // Fill the whole memory so every later read is defined
    send(2'b00, 8'h00, 1'b0);
    for (int a = 0; a < 256; a++) send(2'b01, 8'($urandom), 1'b0);

    // Reset in the middle of an 8-word burst
    send(2'b10, 8'h40, 1'b0);
    send(2'b11, 8'h07, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tv", {31'b0, if1.tx_valid}, 32'd0);
    check("mid_rst_dout", {24'b0, if1.dout}, 32'd0);
    check("mid_rst_rr", {31'b0, if1.rx_ready}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("mid_rel_rr_low", {31'b0, if1.rx_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("mid_rel_rr_high", {31'b0, if1.rx_ready}, 32'd1);
    check("mid_rel_tv", {31'b0, if1.tx_valid}, 32'd0);
    send(2'b10, 8'h40, 1'b0);
    send(2'b11, 8'h00, 1'b0);
    check("post_rst_tv", {31'b0, if1.tx_valid}, 32'd1);
    check("post_rst_dout", {24'b0, if1.dout}, {24'b0, ref_mem[8'h40]});
    wait_drain();

    // Command held while a read word is pending: accepted exactly once
    send(2'b00, 8'h60, 1'b0);
    if1.tx_ready = 1'b0;
    send(2'b11, 8'h00, 1'b0);
    fork
      send(2'b01, 8'h55, 1'b0);
      begin
        repeat (4) begin
          @(posedge clk);
          #1;
          check("block_rr", {31'b0, if1.rx_ready}, 32'd0);
          check("block_tv", {31'b0, if1.tx_valid}, 32'd1);
        end
        if1.tx_ready = 1'b1;
      end
    join
    send(2'b01, 8'h66, 1'b0);
    send(2'b10, 8'h60, 1'b0);
    send(2'b11, 8'h01, 1'b0);
    check("block_once_a", {24'b0, if1.dout}, 32'h55);
    @(posedge clk);
    #1;
    check("block_once_b", {24'b0, if1.dout}, 32'h66);
    wait_drain();

    // Random commands with random tx back-pressure
    for (int it = 0; it < 400; it++) begin
      send(2'($urandom_range(0, 3)), 8'($urandom), 1'b1);
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
          if1.tx_ready = ($urandom_range(0, 3) != 0);
        end
      end
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
